// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the serial program loader.
// SYNC opens a frame; ACK / NAK are the single-byte responses.
package loader_pkg;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA,
        CSUM,
        RESP
    } state_e;

endpackage

// File: rtl/loader_byte_shift.sv
// Little-endian 32-bit byte assembler shared by the ADDR, COUNT and DATA fields.
//   clk, rst  : clock, asynchronous active-low reset
//   clr_i     : restart assembly at byte 0 (wins over shift_i)
//   shift_i   : byte_i is accepted this cycle
//   byte_i    : incoming byte
//   cnt_o     : index of the byte position byte_i lands in
//   word_o    : assembled word including byte_i; meaningful while shift_i=1
module loader_byte_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // The current byte is merged combinationally so the owner can act on the
    // completed field in the same cycle the last byte is accepted.
    always_comb begin
        word_d = word_q;
        word_d[{cnt_q, 3'b000} +: 8] = byte_i;
        cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = word_d;

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses SYNC/ADDR/COUNT/PAYLOAD/CSUM frames from the
// UART receive path, writes payload words to instruction memory and answers
// ACK/NAK. Holds the CPU in reset while a frame is in flight.
//   clk, rst            : clock, asynchronous active-low reset
//   rx_data/valid/ready : byte stream from UART receiver
//   tx_data/valid/ready : response byte to UART transmitter
//   mem_addr/din/we     : memory word write port (registered, one-cycle we)
//   cpu_rst             : active-high CPU reset request
//   busy                : frame in progress
//   err                 : last frame failed (sticky until next SYNC)
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter bit          BOOT_HOLD  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_we,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  err
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic                  misalign_q;
    logic [15:0]           count_q;
    logic [15:0]           idx_q;
    logic [7:0]            csum_q;
    logic [7:0]            tx_data_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_din_q;
    logic [3:0]            mem_we_q;
    logic                  cpu_rst_q;
    logic                  err_q;

    logic                  acc;
    logic                  sh_clr, sh_shift;
    logic [1:0]            sh_cnt;
    logic [31:0]           sh_word;
    logic                  unused_word;

    assign acc      = rx_valid && rx_ready;
    assign sh_shift = acc && (state_q == ADDR || state_q == COUNT || state_q == DATA);
    // COUNT is only two bytes long, so the assembler is rewound after it.
    assign sh_clr   = (acc && state_q == IDLE && rx_data == SYNC)
                   || (acc && state_q == COUNT && sh_cnt == 2'd1);
    assign unused_word = ^sh_word;

    loader_byte_shift u_shift (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sh_clr),
        .shift_i (sh_shift),
        .byte_i  (rx_data),
        .cnt_o   (sh_cnt),
        .word_o  (sh_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            misalign_q <= 1'b0;
            count_q    <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= '0;
            cpu_rst_q  <= BOOT_HOLD;
            err_q      <= 1'b0;
        end else begin
            mem_we_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (acc && rx_data == SYNC) begin
                        state_q   <= ADDR;
                        csum_q    <= '0;
                        cpu_rst_q <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                ADDR: begin
                    if (acc) begin
                        csum_q <= csum_q + rx_data;
                        if (sh_cnt == 2'd3) begin
                            waddr_q    <= sh_word[ADDR_WIDTH+1:2];
                            misalign_q <= (sh_word[1:0] != 2'b00);
                            state_q    <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (acc) begin
                        csum_q <= csum_q + rx_data;
                        if (sh_cnt == 2'd1) begin
                            count_q <= sh_word[15:0];
                            idx_q   <= '0;
                            state_q <= (sh_word[15:0] == 16'd0) ? CSUM : DATA;
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
                        csum_q <= csum_q + rx_data;
                        if (sh_cnt == 2'd3) begin
                            // Misaligned frames are still consumed but never written.
                            if (!misalign_q) begin
                                mem_we_q   <= 4'hF;
                                mem_addr_q <= waddr_q;
                                mem_din_q  <= sh_word;
                            end
                            waddr_q <= waddr_q + ADDR_WIDTH'(1);
                            idx_q   <= idx_q + 16'd1;
                            if (idx_q == count_q - 16'd1) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (acc) begin
                        tx_data_q <= (rx_data == csum_q && !misalign_q) ? ACK : NAK;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        state_q <= IDLE;
                        if (tx_data_q == ACK) begin
                            cpu_rst_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_ready = (state_q != RESP);
    assign tx_valid = (state_q == RESP);
    assign busy     = (state_q != IDLE);
    assign tx_data  = tx_data_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign cpu_rst  = cpu_rst_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_we;
    logic          cpu_rst;
    logic          busy;
    logic          err;

    imem_loader #(.ADDR_WIDTH(AW), .BOOT_HOLD(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [7:0]  fr_q[$];
    logic [31:0] pay_q[$];
    logic [7:0]  exp_resp;
    logic        m_cpu_rst = 1'b0;
    logic        m_err     = 1'b0;
    bit          gaps      = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every memory write strobe seen by the memory port.
    always @(negedge clk) begin
        if (mem_we !== 4'h0) begin
            obs_q.push_back('{we: 32'(mem_we), addr: 32'(mem_addr), data: mem_din});
        end
    end

    // Build the frame byte stream and expected writes/response from the
    // frame rules: payload word i lands at (ADDR/4 + i) mod 2^AW.
    task automatic build_frame(input logic [31:0] addr, input logic [15:0] cnt,
                               input logic [7:0] csum_delta);
        int unsigned sum;
        logic [31:0] w;
        fr_q.delete();
        exp_q.delete();
        fr_q.push_back(8'hA5);
        for (int k = 0; k < 4; k++) fr_q.push_back(addr[8*k +: 8]);
        fr_q.push_back(cnt[7:0]);
        fr_q.push_back(cnt[15:8]);
        for (int i = 0; i < int'(cnt); i++) begin
            w = pay_q[i];
            for (int k = 0; k < 4; k++) fr_q.push_back(w[8*k +: 8]);
            if (addr[1:0] == 2'b00) begin
                exp_q.push_back('{we: 32'hF,
                                  addr: ((addr >> 2) + 32'(i)) % (32'd1 << AW),
                                  data: w});
            end
        end
        sum = 0;
        for (int i = 1; i < fr_q.size(); i++) sum += fr_q[i];
        fr_q.push_back(8'((sum + csum_delta) % 256));
        exp_resp = (csum_delta == 8'd0 && addr[1:0] == 2'b00) ? 8'h06 : 8'h15;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int unsigned t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("rx_ready_wait", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom());
    endtask

    task automatic send_bytes(input int unsigned n);
        for (int unsigned i = 0; i < n && i < fr_q.size(); i++) send_byte(fr_q[i]);
    endtask

    task automatic run_frame(input int unsigned hold);
        int unsigned n;
        obs_q.delete();
        send_bytes(fr_q.size());
        m_cpu_rst = 1'b1;
        m_err     = 1'b0;
        check("resp_tx_valid", 32'(tx_valid), 32'd1);
        check("resp_tx_data",  32'(tx_data),  32'(exp_resp));
        check("resp_rx_ready", 32'(rx_ready), 32'd0);
        check("resp_busy",     32'(busy),     32'd1);
        check("resp_cpu_rst",  32'(cpu_rst),  32'(m_cpu_rst));
        check("resp_err",      32'(err),      32'(m_err));
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_tx_valid", 32'(tx_valid), 32'd1);
            check("hold_tx_data",  32'(tx_data),  32'(exp_resp));
            check("hold_rx_ready", 32'(rx_ready), 32'd0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        if (exp_resp == 8'h06) m_cpu_rst = 1'b0;
        else m_err = 1'b1;
        check("post_busy",     32'(busy),     32'd0);
        check("post_tx_valid", 32'(tx_valid), 32'd0);
        check("post_cpu_rst",  32'(cpu_rst),  32'(m_cpu_rst));
        check("post_err",      32'(err),      32'(m_err));
        check("nwrites", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check("wr_we",   obs_q[i].we,   exp_q[i].we);
            check("wr_addr", obs_q[i].addr, exp_q[i].addr);
            check("wr_data", obs_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_din"},  32'(mem_din),  32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] c;
        logic [7:0]  d;

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;
        @(negedge clk);

        // Stray bytes before SYNC are dropped.
        obs_q.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("stray_busy",    32'(busy),         32'd0);
        check("stray_writes",  32'(obs_q.size()), 32'd0);
        check("stray_cpu_rst", 32'(cpu_rst),      32'd0);

        // Single word to byte address 0x10.
        pay_q = '{32'h0000_0013};
        build_frame(32'h10, 16'd1, 8'd0);
        check("frameA_csum_byte", 32'(fr_q[fr_q.size()-1]), 32'h24);
        run_frame(0);

        // Same frame with a bad checksum.
        build_frame(32'h10, 16'd1, 8'd1);
        run_frame(1);

        // Misaligned address: consumed, no write, NAK.
        pay_q = '{32'hDEAD_BEEF};
        build_frame(32'h12, 16'd1, 8'd0);
        run_frame(0);

        // Empty frame.
        pay_q.delete();
        build_frame(32'h0, 16'd0, 8'd0);
        run_frame(0);

        // Top word then wrap to word 0, with transmitter backpressure.
        pay_q = '{32'h1122_3344, 32'h5566_7788};
        build_frame(((32'd1 << AW) - 32'd1) << 2, 16'd2, 8'd0);
        run_frame(5);

        // Reset pulsed after 3 payload bytes.
        pay_q = '{32'hCAFE_F00D};
        build_frame(32'h40, 16'd1, 8'd0);
        obs_q.delete();
        send_bytes(10);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        check("midrst_writes", 32'(obs_q.size()), 32'd0);
        rst = 1'b1;
        m_cpu_rst = 1'b0;
        m_err     = 1'b0;
        @(negedge clk);
        pay_q = '{32'h0BAD_C0DE, 32'h1357_9BDF};
        build_frame(32'h80, 16'd2, 8'd0);
        run_frame(0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            a = $urandom();
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            c = 16'($urandom_range(0, 6));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            pay_q.delete();
            for (int i = 0; i < int'(c); i++) pay_q.push_back($urandom());
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'($urandom_range(0, 8'hA4)));
            end
            build_frame(a, c, d);
            run_frame($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
